// File: rtl/reaction_timer_counter.sv
// -----------------------------------------------------------------------------
// reaction_timer_counter
//   Millisecond reaction-time counter fed by the game control logic. It counts
//   elapsed ticks as a 4-digit packed-BCD value for the seven-segment stage,
//   saturates at 9999, latches the foul flag when the count is stopped, and
//   emits a one-cycle completion pulse when the count enters HOLD.
//
// Parameters
//   CLK_HZ   input clock frequency in Hz
//   TICK_HZ  count rate in Hz; DIV = CLK_HZ/TICK_HZ, must be >= 2
//
// Ports
//   clk_50M      in   1   system clock, all logic on posedge
//   rst          in   1   synchronous active-high reset, highest priority
//   CounterFlag  in   2   00 clear, 01 hold, 10 run, 11 treated as hold
//   ErrorFlag    in   1   foul indication, sampled with CounterFlag
//   bcd_out      out  16  elapsed count, [15:12]=thousands .. [3:0]=units
//   overflow     out  1   count saturated at 9999
//   foul         out  1   ErrorFlag captured on entry to HOLD
//   running      out  1   high while in RUN
//   done         out  1   one-cycle pulse on entry to HOLD
// -----------------------------------------------------------------------------
module reaction_timer_counter #(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 1000
) (
   input  logic        clk_50M,
   input  logic        rst,
   input  logic [1:0]  CounterFlag,
   input  logic        ErrorFlag,
   output logic [15:0] bcd_out,
   output logic        overflow,
   output logic        foul,
   output logic        running,
   output logic        done
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic [1:0]    prev_flag;

   // Decimal increment: each nibble wraps 9 -> 0 and carries into the next.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               c = 1'b0;
            end
         end
      end
      return r;
   endfunction

   // Saturation point of the display: all four digits at 9.
   function automatic logic bcd_at_max(input logic [15:0] v);
      return (v == 16'h9999);
   endfunction

   // state is a flop, so this decode adds no combinational path from inputs.
   assign running = (state == RUN);

   always_ff @(posedge clk_50M) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         prev_flag <= 2'b00;
         bcd_out   <= 16'h0000;
         overflow  <= 1'b0;
         foul      <= 1'b0;
         done      <= 1'b0;
      end else begin
         prev_flag <= CounterFlag;
         done      <= 1'b0;
         case (CounterFlag)
            2'b00: begin
               state     <= IDLE;
               prescaler <= '0;
               bcd_out   <= 16'h0000;
               overflow  <= 1'b0;
               foul      <= 1'b0;
            end
            2'b10: begin
               state <= RUN;
               if (prescaler == PRE_LAST) begin
                  prescaler <= '0;
                  if (bcd_at_max(bcd_out)) begin
                     overflow <= 1'b1;
                  end else begin
                     bcd_out <= bcd_inc(bcd_out);
                  end
               end else begin
                  prescaler <= prescaler + PW'(1);
               end
            end
            default: begin
               // 01 and 11 both hold; a pending tick is simply dropped with
               // the prescaler, so there is no partial-ms rounding.
               state     <= HOLD;
               prescaler <= '0;
               // Both hold codes have bit 0 set, so a clear bit 0 in the
               // previous flag means this edge is the entry into HOLD.
               if (!prev_flag[0]) begin
                  done <= 1'b1;
                  foul <= ErrorFlag;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reaction_timer_counter.sv
module tb_reaction_timer_counter;

   localparam int DIV = 10;

   logic        clk_50M;
   logic        rst;
   logic [1:0]  CounterFlag;
   logic        ErrorFlag;
   logic [15:0] bcd_out;
   logic        overflow, foul, running, done;

   // second instance with a short divider so saturation is reachable quickly
   logic        of_rst;
   logic [1:0]  of_flag;
   logic        of_err;
   logic [15:0] of_bcd;
   logic        of_ovf, of_foul, of_running, of_done;

   int n_checks = 0;
   int n_fail   = 0;

   // behavioural model state
   int         m_cnt;
   int         m_run;
   logic [1:0] m_prev;
   logic       m_ovf, m_foul, m_done, m_running;

   reaction_timer_counter #(.CLK_HZ(10), .TICK_HZ(1)) u_dut (
      .clk_50M(clk_50M), .rst(rst), .CounterFlag(CounterFlag), .ErrorFlag(ErrorFlag),
      .bcd_out(bcd_out), .overflow(overflow), .foul(foul), .running(running), .done(done)
   );

   reaction_timer_counter #(.CLK_HZ(2), .TICK_HZ(1)) u_ovf (
      .clk_50M(clk_50M), .rst(of_rst), .CounterFlag(of_flag), .ErrorFlag(of_err),
      .bcd_out(of_bcd), .overflow(of_ovf), .foul(of_foul), .running(of_running), .done(of_done)
   );

   initial clk_50M = 1'b0;
   always #5 clk_50M = ~clk_50M;

   function automatic logic [15:0] to_bcd(input int c);
      return {4'(c / 1000 % 10), 4'(c / 100 % 10), 4'(c / 10 % 10), 4'(c % 10)};
   endfunction

   function automatic logic is_decimal(input logic [15:0] v);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
      return ok;
   endfunction

   // Model: count in plain integers; a tick every DIV consecutive run edges.
   function automatic void model_edge(input logic [1:0] f, input logic e, input logic r);
      if (r) begin
         m_cnt = 0; m_run = 0; m_prev = 2'b00;
         m_ovf = 0; m_foul = 0; m_done = 0; m_running = 0;
         return;
      end
      m_done = 0;
      if (f == 2'b00) begin
         m_cnt = 0; m_run = 0; m_ovf = 0; m_foul = 0; m_running = 0;
      end else if (f == 2'b10) begin
         m_run++;
         m_running = 1;
         if (m_run % DIV == 0) begin
            if (m_cnt == 9999) m_ovf = 1;
            else m_cnt++;
         end
      end else begin
         m_run = 0;
         m_running = 0;
         if (m_prev != 2'b01 && m_prev != 2'b11) begin
            m_done = 1;
            m_foul = e;
         end
      end
      m_prev = f;
   endfunction

   task automatic step(input logic [1:0] f, input logic e, input logic r);
      CounterFlag = f;
      ErrorFlag   = e;
      rst         = r;
      @(posedge clk_50M);
      model_edge(f, e, r);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b1);
      n_checks++;
      if ({bcd_out, overflow, foul, running, done} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset: bcd=%h ovf=%b foul=%b run=%b done=%b, expected all 0",
                  bcd_out, overflow, foul, running, done);
      end
   endtask

   task automatic test_basic();
      int pulses;
      step(2'b00, 1'b0, 1'b0);
      for (int i = 1; i <= 35; i++) begin
         step(2'b10, 1'b0, 1'b0);
         if (i == 1) begin
            n_checks++;
            if (running !== 1'b1) begin
               n_fail++; $display("FAIL basic_running: got %b, expected 1", running);
            end
         end
         if (i == 9 || i == 10) begin
            n_checks++;
            if (bcd_out !== ((i == 10) ? 16'h0001 : 16'h0000)) begin
               n_fail++; $display("FAIL basic_first_tick edge %0d: got %h", i, bcd_out);
            end
         end
      end
      step(2'b01, 1'b0, 1'b0);
      n_checks++;
      if ({bcd_out, running, done, foul} !== {16'h0003, 1'b0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL basic_stop: bcd=%h run=%b done=%b foul=%b, expected 0003 0 1 0",
                  bcd_out, running, done, foul);
      end
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         step((i % 2) ? 2'b11 : 2'b01, 1'b1, 1'b0);
         if (done) pulses++;
      end
      n_checks++;
      if (pulses != 0 || bcd_out !== 16'h0003 || foul !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_hold: extra pulses=%0d bcd=%h foul=%b, expected 0 0003 0",
                  pulses, bcd_out, foul);
      end
   endtask

   task automatic test_carry();
      logic dec_ok;
      dec_ok = 1'b1;
      step(2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         step(2'b10, 1'b0, 1'b0);
         if (!is_decimal(bcd_out)) dec_ok = 1'b0;
      end
      n_checks++;
      if (bcd_out !== 16'h0100 || dec_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL carry: bcd=%h decimal=%b, expected 0100 1", bcd_out, dec_ok);
      end
   endtask

   task automatic test_foul_before_start();
      step(2'b00, 1'b0, 1'b0);
      step(2'b01, 1'b1, 1'b0);
      n_checks++;
      if ({done, foul, bcd_out} !== {1'b1, 1'b1, 16'h0000}) begin
         n_fail++;
         $display("FAIL foul_entry: done=%b foul=%b bcd=%h, expected 1 1 0000", done, foul, bcd_out);
      end
      step(2'b01, 1'b0, 1'b0);
      n_checks++;
      if ({done, foul} !== 2'b01) begin
         n_fail++; $display("FAIL foul_hold: done=%b foul=%b, expected 0 1", done, foul);
      end
      step(2'b00, 1'b0, 1'b0);
      n_checks++;
      if (foul !== 1'b0) begin
         n_fail++; $display("FAIL foul_clear: got %b, expected 0", foul);
      end
   endtask

   task automatic test_reset_midrun();
      step(2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 420; i++) step(2'b10, 1'b0, 1'b0);
      n_checks++;
      if (bcd_out !== 16'h0042) begin
         n_fail++; $display("FAIL midrun_count: got %h, expected 0042", bcd_out);
      end
      step(2'b10, 1'b0, 1'b1);
      n_checks++;
      if ({bcd_out, overflow, foul, running, done} !== 20'h0) begin
         n_fail++; $display("FAIL midrun_reset: bcd=%h run=%b, expected 0000 0", bcd_out, running);
      end
      for (int i = 1; i <= 10; i++) begin
         step(2'b10, 1'b0, 1'b0);
         if (i >= 9) begin
            n_checks++;
            if (bcd_out !== ((i == 10) ? 16'h0001 : 16'h0000)) begin
               n_fail++; $display("FAIL midrun_restart edge %0d: got %h", i, bcd_out);
            end
         end
      end
   endtask

   task automatic test_stop_on_tick();
      step(2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 19; i++) step(2'b10, 1'b0, 1'b0);
      step(2'b01, 1'b0, 1'b0);
      n_checks++;
      if (bcd_out !== 16'h0001 || done !== 1'b1) begin
         n_fail++; $display("FAIL stop_on_tick: bcd=%h done=%b, expected 0001 1", bcd_out, done);
      end
      for (int i = 0; i < 4; i++) step(2'b01, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(2'b10, 1'b0, 1'b0);
         if (i >= 9) begin
            n_checks++;
            if (bcd_out !== ((i == 10) ? 16'h0002 : 16'h0001)) begin
               n_fail++; $display("FAIL resume edge %0d: got %h", i, bcd_out);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] f;
      int len, sel;
      int k;
      k = 0;
      for (int s = 0; s < 70; s++) begin
         sel = $urandom_range(0, 9);
         f   = (sel < 2) ? 2'b00 : (sel < 4) ? 2'b01 : (sel == 4) ? 2'b11 : 2'b10;
         len = $urandom_range(1, 25);
         for (int j = 0; j < len; j++) begin
            step(f, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
            k++;
            n_checks++;
            if ({bcd_out, overflow, foul, running, done} !==
                {to_bcd(m_cnt), m_ovf, m_foul, m_running, m_done}) begin
               n_fail++;
               $display("FAIL random step %0d: got bcd=%h ovf=%b foul=%b run=%b done=%b, expected %h %b %b %b %b",
                        k, bcd_out, overflow, foul, running, done,
                        to_bcd(m_cnt), m_ovf, m_foul, m_running, m_done);
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic dec_ok;
      dec_ok = 1'b1;
      of_rst = 1'b1; of_flag = 2'b00; of_err = 1'b0;
      @(posedge clk_50M); #1;
      of_rst  = 1'b0;
      of_flag = 2'b10;
      for (int i = 0; i < 19998; i++) begin
         @(posedge clk_50M); #1;
         if (!is_decimal(of_bcd)) dec_ok = 1'b0;
      end
      n_checks++;
      if (of_bcd !== 16'h9999 || of_ovf !== 1'b0 || dec_ok !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_reach: bcd=%h ovf=%b decimal=%b, expected 9999 0 1", of_bcd, of_ovf, dec_ok);
      end
      for (int i = 0; i < 2; i++) begin @(posedge clk_50M); #1; end
      n_checks++;
      if (of_bcd !== 16'h9999 || of_ovf !== 1'b1) begin
         n_fail++; $display("FAIL ovf_set: bcd=%h ovf=%b, expected 9999 1", of_bcd, of_ovf);
      end
      for (int i = 0; i < 100; i++) begin @(posedge clk_50M); #1; end
      n_checks++;
      if (of_bcd !== 16'h9999 || of_ovf !== 1'b1) begin
         n_fail++; $display("FAIL ovf_hold: bcd=%h ovf=%b, expected 9999 1", of_bcd, of_ovf);
      end
      of_flag = 2'b00;
      @(posedge clk_50M); #1;
      n_checks++;
      if (of_bcd !== 16'h0000 || of_ovf !== 1'b0) begin
         n_fail++; $display("FAIL ovf_clear: bcd=%h ovf=%b, expected 0000 0", of_bcd, of_ovf);
      end
   endtask

   initial begin
      rst = 1'b1; CounterFlag = 2'b00; ErrorFlag = 1'b0;
      of_rst = 1'b1; of_flag = 2'b00; of_err = 1'b0;
      model_edge(2'b00, 1'b0, 1'b1);
      test_reset();
      test_basic();
      test_carry();
      test_foul_before_start();
      test_reset_midrun();
      test_stop_on_tick();
      test_random();
      step(2'b00, 1'b0, 1'b0);
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
